// File: rtl/da_wave_ctrl.sv
// Run-time controller for the DAC trapezoid/sawtooth generator.
// Debounces four active-low keys, walks between four waveform profiles and
// hands each new profile to the generator through a cfg_valid/cfg_ack
// handshake.
//
// Handshake: cfg_valid rises on the same edge that loads cfg_*, and cfg_*
// stay frozen while cfg_valid is high. The generator accepts by raising
// cfg_ack in any cycle where cfg_valid is high; cfg_valid drops on the next
// edge. cfg_ack seen while cfg_valid is low has no effect. If no ack arrives
// within ACK_TIMEOUT cycles the offer is withdrawn and cfg_err latches.
module da_wave_ctrl #(
    parameter int          DEBOUNCE_CYCLES = 1000000,
    parameter int          ACK_TIMEOUT     = 1024,
    parameter logic [13:0] P0_INC = 14'h131,
    parameter logic [13:0] P0_DEC = 14'h065,
    parameter logic [7:0]  P0_UP  = 8'h7F,
    parameter logic [7:0]  P0_DN  = 8'h1F,
    parameter logic [13:0] P1_INC = 14'h131,
    parameter logic [13:0] P1_DEC = 14'h065,
    parameter logic [7:0]  P1_UP  = 8'h01,
    parameter logic [7:0]  P1_DN  = 8'h01,
    parameter logic [13:0] P2_INC = 14'h262,
    parameter logic [13:0] P2_DEC = 14'h262,
    parameter logic [7:0]  P2_UP  = 8'h3F,
    parameter logic [7:0]  P2_DN  = 8'h3F,
    parameter logic [13:0] P3_INC = 14'h099,
    parameter logic [13:0] P3_DEC = 14'h033,
    parameter logic [7:0]  P3_UP  = 8'hFF,
    parameter logic [7:0]  P3_DN  = 8'h00
) (
    input  logic        CLOCK_100,
    input  logic        rst_n,
    input  logic [3:0]  KEY,
    input  logic        gen_cycle_done,
    input  logic        cfg_ack,
    output logic [13:0] cfg_inc,
    output logic [13:0] cfg_dec,
    output logic [7:0]  cfg_plateup,
    output logic [7:0]  cfg_platedown,
    output logic        cfg_valid,
    output logic        gen_enable,
    output logic [1:0]  profile_idx,
    output logic        cfg_err
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] PEND  = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] UPD   = 2'd3;

    // Packed profile word {inc, dec, plateup, platedown}
    function automatic logic [43:0] profile(input logic [1:0] idx);
        case (idx)
            2'd0:    return {P0_INC, P0_DEC, P0_UP, P0_DN};
            2'd1:    return {P1_INC, P1_DEC, P1_UP, P1_DN};
            2'd2:    return {P2_INC, P2_DEC, P2_UP, P2_DN};
            default: return {P3_INC, P3_DEC, P3_UP, P3_DN};
        endcase
    endfunction

    logic [3:0]      key_meta, key_sync, key_lvl, key_press;
    logic [DB_W-1:0] db_cnt [4];

    logic [1:0]      state, active, pending;
    logic [TO_W-1:0] timer;

    // Two-flop synchroniser for the asynchronous pushbuttons (idle high)
    always_ff @(posedge CLOCK_100 or negedge rst_n) begin
        if (!rst_n) begin
            key_meta <= 4'hF;
            key_sync <= 4'hF;
        end else begin
            key_meta <= KEY;
            key_sync <= key_meta;
        end
    end

    // Per-key debounce: accept a new level after DEBOUNCE_CYCLES stable cycles; pulse on accepted press
    always_ff @(posedge CLOCK_100 or negedge rst_n) begin
        if (!rst_n) begin
            key_lvl   <= 4'hF;
            key_press <= 4'h0;
            for (int k = 0; k < 4; k++) db_cnt[k] <= '0;
        end else begin
            key_press <= 4'h0;
            for (int k = 0; k < 4; k++) begin
                if (key_sync[k] == key_lvl[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DB_LAST) begin
                    db_cnt[k]    <= '0;
                    key_lvl[k]   <= key_sync[k];
                    key_press[k] <= ~key_sync[k];
                end else begin
                    db_cnt[k] <= db_cnt[k] + 1'b1;
                end
            end
        end
    end

    // Same-cycle presses resolve as home > pause/run > next > prev
    logic home, pp, nxt, prv, step;
    logic [1:0] base_idx, step_idx;

    assign home = key_press[3];
    assign pp   = key_press[2] & ~key_press[3];
    assign nxt  = key_press[0] & ~key_press[3] & ~key_press[2];
    assign prv  = key_press[1] & ~key_press[3] & ~key_press[2] & ~key_press[0];
    assign step = nxt | prv;

    assign base_idx = (state == PEND) ? pending : active;
    assign step_idx = nxt ? base_idx + 2'd1 : base_idx - 2'd1;

    // Key-driven decisions for RUN/PEND/PAUSE; UPD ignores keys entirely
    logic       go_upd, clr_err, nx_gen_en;
    logic [1:0] go_idx, nx_state, nx_pending;

    always_comb begin
        go_upd     = 1'b0;
        go_idx     = pending;
        clr_err    = 1'b0;
        nx_gen_en  = gen_enable;
        nx_state   = state;
        nx_pending = pending;
        case (state)
            RUN: begin
                if (home) begin
                    go_upd  = 1'b1;
                    go_idx  = 2'd0;
                    clr_err = 1'b1;
                end else if (pp) begin
                    nx_gen_en = 1'b0;
                    nx_state  = PAUSE;
                end else if (step) begin
                    nx_pending = step_idx;
                    nx_state   = PEND;
                end
            end
            PEND: begin
                if (home) begin
                    go_upd  = 1'b1;
                    go_idx  = 2'd0;
                    clr_err = 1'b1;
                end else if (pp) begin
                    nx_gen_en = 1'b0;
                    go_upd    = 1'b1;
                end else if (step) begin
                    if (step_idx == active) begin
                        nx_pending = active;
                        nx_state   = RUN;
                    end else if (gen_cycle_done) begin
                        go_upd = 1'b1;
                        go_idx = step_idx;
                    end else begin
                        nx_pending = step_idx;
                    end
                end else if (gen_cycle_done) begin
                    go_upd = 1'b1;
                end
            end
            PAUSE: begin
                if (home) begin
                    go_upd    = 1'b1;
                    go_idx    = 2'd0;
                    clr_err   = 1'b1;
                    nx_gen_en = 1'b1;
                end else if (pp) begin
                    nx_gen_en = 1'b1;
                    nx_state  = RUN;
                end else if (step) begin
                    go_upd = 1'b1;
                    go_idx = step_idx;
                end
            end
            default: ;
        endcase
    end

    // Main FSM: profile bookkeeping, cfg handshake and ack timeout
    always_ff @(posedge CLOCK_100 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            active      <= 2'd0;
            pending     <= 2'd0;
            {cfg_inc, cfg_dec, cfg_plateup, cfg_platedown} <= profile(2'd0);
            cfg_valid   <= 1'b0;
            gen_enable  <= 1'b1;
            cfg_err     <= 1'b0;
            timer       <= '0;
        end else if (state == UPD) begin
            if (cfg_ack) begin
                active    <= pending;
                cfg_valid <= 1'b0;
                state     <= gen_enable ? RUN : PAUSE;
            end else if (timer == TO_LAST) begin
                cfg_err   <= 1'b1;
                cfg_valid <= 1'b0;
                pending   <= active;
                {cfg_inc, cfg_dec, cfg_plateup, cfg_platedown} <= profile(active);
                state     <= gen_enable ? RUN : PAUSE;
            end else begin
                timer <= timer + 1'b1;
            end
        end else begin
            gen_enable <= nx_gen_en;
            if (clr_err) cfg_err <= 1'b0;
            if (go_upd) begin
                state     <= UPD;
                pending   <= go_idx;
                {cfg_inc, cfg_dec, cfg_plateup, cfg_platedown} <= profile(go_idx);
                cfg_valid <= 1'b1;
                timer     <= '0;
            end else begin
                state   <= nx_state;
                pending <= nx_pending;
            end
        end
    end

    assign profile_idx = active;

endmodule

// File: tb/tb_da_wave_ctrl.sv
// Directed bench for da_wave_ctrl with short debounce and ack timeout.
module tb_da_wave_ctrl;

    localparam int DEB = 4;
    localparam int ATO = 8;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_PEND  = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_UPD   = 2'd3;

    logic        clk;
    logic        rst_n;
    logic [3:0]  key;
    logic        gen_cycle_done;
    logic        cfg_ack;
    logic [13:0] cfg_inc, cfg_dec;
    logic [7:0]  cfg_plateup, cfg_platedown;
    logic        cfg_valid, gen_enable, cfg_err;
    logic [1:0]  profile_idx;

    int n_pass  = 0;
    int n_total = 0;
    int valid_cycles = 0;
    int press0_cnt   = 0;
    int vc_snap, pc_snap;

    da_wave_ctrl #(.DEBOUNCE_CYCLES(DEB), .ACK_TIMEOUT(ATO)) dut (
        .CLOCK_100      (clk),
        .rst_n          (rst_n),
        .KEY            (key),
        .gen_cycle_done (gen_cycle_done),
        .cfg_ack        (cfg_ack),
        .cfg_inc        (cfg_inc),
        .cfg_dec        (cfg_dec),
        .cfg_plateup    (cfg_plateup),
        .cfg_platedown  (cfg_platedown),
        .cfg_valid      (cfg_valid),
        .gen_enable     (gen_enable),
        .profile_idx    (profile_idx),
        .cfg_err        (cfg_err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Activity monitors
    always @(posedge clk) if (cfg_valid) valid_cycles++;
    always @(posedge clk) if (dut.key_press[0]) press0_cnt++;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Hold a key low long enough to be accepted, then let it go
    task automatic press(input int k);
        key[k] = 1'b0;
        repeat (DEB + 4) tick();
        key[k] = 1'b1;
    endtask

    task automatic ack();
        cfg_ack = 1'b1;
        tick();
        cfg_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        key = 4'hF;
        gen_cycle_done = 1'b0;
        cfg_ack = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset values
        check("rst_inc",   cfg_inc, 14'h131);
        check("rst_dec",   cfg_dec, 14'h065);
        check("rst_up",    cfg_plateup, 8'h7F);
        check("rst_dn",    cfg_platedown, 8'h1F);
        check("rst_en",    gen_enable, 1'b1);
        check("rst_valid", cfg_valid, 1'b0);
        check("rst_idx",   profile_idx, 2'd0);
        check("rst_err",   cfg_err, 1'b0);

        // Next press waits for the waveform boundary
        vc_snap = valid_cycles;
        press(0);
        repeat (12) tick();
        check("pend_state", dut.state, S_PEND);
        check("pend_novalid", valid_cycles - vc_snap, 0);
        check("pend_idx", profile_idx, 2'd0);
        gen_cycle_done = 1'b1;
        tick();
        gen_cycle_done = 1'b0;
        check("upd_valid", cfg_valid, 1'b1);
        check("upd_inc",   cfg_inc, 14'h131);
        check("upd_dec",   cfg_dec, 14'h065);
        check("upd_up",    cfg_plateup, 8'h01);
        check("upd_dn",    cfg_platedown, 8'h01);
        check("upd_idx_hold", profile_idx, 2'd0);
        tick();
        ack();
        check("ack_valid", cfg_valid, 1'b0);
        check("ack_idx",   profile_idx, 2'd1);
        check("ack_state", dut.state, S_RUN);

        // Bounce yields exactly one press
        vc_snap = valid_cycles;
        pc_snap = press0_cnt;
        for (int i = 0; i < 2; i++) begin
            key[0] = 1'b0;
            repeat (2) tick();
            key[0] = 1'b1;
            repeat (2) tick();
        end
        key[0] = 1'b0;
        repeat (DEB + 4) tick();
        key[0] = 1'b1;
        repeat (10) tick();
        check("bounce_pulses", press0_cnt - pc_snap, 1);
        check("bounce_state", dut.state, S_PEND);

        // Prev while pending cancels back to the active profile
        press(1);
        check("cancel_state", dut.state, S_RUN);
        check("cancel_idx", profile_idx, 2'd1);
        check("cancel_novalid", valid_cycles - vc_snap, 0);

        // Home while running goes straight to profile 0
        press(3);
        check("home_valid", cfg_valid, 1'b1);
        check("home_inc",   cfg_inc, 14'h131);
        check("home_up",    cfg_plateup, 8'h7F);
        check("home_dn",    cfg_platedown, 8'h1F);
        ack();
        check("home_idx",   profile_idx, 2'd0);
        check("home_state", dut.state, S_RUN);

        // Pause, then prev applies immediately with no boundary
        repeat (8) tick();
        press(2);
        check("pause_en",    gen_enable, 1'b0);
        check("pause_state", dut.state, S_PAUSE);
        repeat (4) tick();
        press(1);
        check("pprev_valid", cfg_valid, 1'b1);
        check("pprev_inc",   cfg_inc, 14'h099);
        check("pprev_dec",   cfg_dec, 14'h033);
        check("pprev_up",    cfg_plateup, 8'hFF);
        check("pprev_dn",    cfg_platedown, 8'h00);
        check("pprev_en",    gen_enable, 1'b0);
        ack();
        check("pprev_idx",   profile_idx, 2'd3);
        check("pprev_state", dut.state, S_PAUSE);

        // Stray ack outside the handshake is ignored
        ack();
        check("stray_idx",   profile_idx, 2'd3);
        check("stray_state", dut.state, S_PAUSE);

        // No ack: timeout withdraws the offer and latches cfg_err
        vc_snap = valid_cycles;
        press(0);
        check("to_valid", cfg_valid, 1'b1);
        check("to_inc_offer", cfg_inc, 14'h131);
        repeat (10) tick();
        check("to_valid_drop", cfg_valid, 1'b0);
        check("to_err",   cfg_err, 1'b1);
        check("to_len",   valid_cycles - vc_snap, ATO);
        check("to_inc",   cfg_inc, 14'h099);
        check("to_dn",    cfg_platedown, 8'h00);
        check("to_idx",   profile_idx, 2'd3);
        check("to_state", dut.state, S_PAUSE);
        repeat (4) tick();
        check("to_err_sticky", cfg_err, 1'b1);

        // Home from pause clears the error and resumes
        press(3);
        check("clr_err",   cfg_err, 1'b0);
        check("clr_en",    gen_enable, 1'b1);
        check("clr_valid", cfg_valid, 1'b1);
        ack();
        check("clr_idx",   profile_idx, 2'd0);
        check("clr_state", dut.state, S_RUN);

        // Reset mid-handshake aborts to reset values
        repeat (8) tick();
        press(0);
        gen_cycle_done = 1'b1;
        tick();
        gen_cycle_done = 1'b0;
        check("mid_valid", cfg_valid, 1'b1);
        check("mid_up",    cfg_plateup, 8'h01);
        rst_n = 1'b0;
        tick();
        check("abort_valid", cfg_valid, 1'b0);
        check("abort_up",    cfg_plateup, 8'h7F);
        check("abort_idx",   profile_idx, 2'd0);
        check("abort_state", dut.state, S_RUN);
        check("abort_en",    gen_enable, 1'b1);
        rst_n = 1'b1;
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
